// File: rtl/lsu_warp_pkg.sv
// Shared types for the warp-wide load-store unit.
// Provides the scheduler/LSU state enums, data and address types, lane mask/index
// types for the default warp size, and a helper to size lane index vectors.
package lsu_warp_pkg;

  localparam int unsigned LaneCount = 4;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 8;

  // A 1-lane warp still needs a 1-bit index vector.
  function automatic int unsigned lane_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LaneIdxW = lane_idx_width(LaneCount);

  typedef logic [DataWidth-1:0] data_t;
  typedef logic [AddrWidth-1:0] data_memory_address_t;
  typedef logic [LaneCount-1:0] lane_mask_t;
  typedef logic [LaneIdxW-1:0]  lane_idx_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQUESTING,
    LSU_WAITING,
    LSU_DONE
  } lsu_state_t;

  typedef enum logic [2:0] {
    WARP_IDLE,
    WARP_FETCH,
    WARP_DECODE,
    WARP_REQUEST,
    WARP_WAIT,
    WARP_EXECUTE,
    WARP_UPDATE,
    WARP_DONE
  } warp_state_t;

endpackage

// File: rtl/lsu_warp_if.sv
// Shared data-memory port between the warp LSU (master) and memory (slave).
//   mem_read_valid/address   : LSU read request
//   mem_read_ready/data      : memory read acknowledge + data
//   mem_write_valid/address/data : LSU write request
//   mem_write_ready          : memory write acknowledge
interface lsu_warp_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();
  logic              mem_read_valid;
  logic [ADDR_W-1:0] mem_read_address;
  logic              mem_read_ready;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_write_valid;
  logic [ADDR_W-1:0] mem_write_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/lsu_warp_lane_next_finder.sv
// Combinational lane search.
//   mask_i  : active-lane mask
//   idx_i   : current lane index
//   first_i : 1 = search from lane 0 inclusive, 0 = search strictly above idx_i
//   next_o  : lowest qualifying set lane
//   found_o : a qualifying lane exists
module lsu_warp_lane_next_finder #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] mask_i,
  input  logic [LANE_W-1:0]    idx_i,
  input  logic                 first_i,
  output logic [LANE_W-1:0]    next_o,
  output logic                 found_o
);

  // Scan downwards so the lowest qualifying lane is the last one assigned.
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (mask_i[i] && (first_i || (i > int'(idx_i)))) begin
        next_o  = LANE_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_warp.sv
// Warp-wide load-store unit: serialises the LDR/STR accesses of all active lanes
// onto one shared data-memory port, with optional same-address load coalescing.
//   clk, reset_n (async, active-low), enable (0 = freeze)
//   warp_state, decoded_mem_read_enable/write_enable : instruction handshake
//   thread_mask, rs1 (base), rs2 (store data), imm    : per-instruction operands
//   mem                                               : shared memory port (master)
//   lsu_state, lsu_out                                : aggregate state, per-lane loads
module lsu_warp
  import lsu_warp_pkg::*;
#(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned COALESCE  = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  warp_state_t                 warp_state,
  input  logic                        decoded_mem_read_enable,
  input  logic                        decoded_mem_write_enable,
  input  logic [NUM_LANES-1:0]        thread_mask,
  input  logic [NUM_LANES*DATA_W-1:0] rs1,
  input  logic [NUM_LANES*DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0]           imm,
  lsu_warp_if.master                  mem,
  output lsu_state_t                  lsu_state,
  output logic [NUM_LANES*DATA_W-1:0] lsu_out
);

  localparam int unsigned LaneW = lane_idx_width(NUM_LANES);

  lsu_state_t                        state_q, state_d;
  logic                              is_load_q, is_load_d;
  logic                              coal_q, coal_d;
  logic [NUM_LANES-1:0]              mask_q, mask_d;
  logic [LaneW-1:0]                  lane_q, lane_d;
  logic [NUM_LANES-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]  wdata_q, wdata_d;
  logic [NUM_LANES-1:0][DATA_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0]                 hold_q, hold_d;
  logic                              rvalid_q, rvalid_d, wvalid_q, wvalid_d;
  logic [ADDR_W-1:0]                 raddr_q, raddr_d, waddr_q, waddr_d;
  logic [DATA_W-1:0]                 mwdata_q, mwdata_d;

  logic [LaneW-1:0] first_idx, next_idx;
  logic             first_found, next_found, step;

  lsu_warp_lane_next_finder #(.NUM_LANES(NUM_LANES), .LANE_W(LaneW)) u_first (
    .mask_i  (thread_mask),
    .idx_i   ('0),
    .first_i (1'b1),
    .next_o  (first_idx),
    .found_o (first_found)
  );

  lsu_warp_lane_next_finder #(.NUM_LANES(NUM_LANES), .LANE_W(LaneW)) u_next (
    .mask_i  (mask_q),
    .idx_i   (lane_q),
    .first_i (1'b0),
    .next_o  (next_idx),
    .found_o (next_found)
  );

  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    coal_d    = coal_q;
    mask_d    = mask_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    out_d     = out_q;
    hold_d    = hold_q;
    rvalid_d  = rvalid_q;
    wvalid_d  = wvalid_q;
    raddr_d   = raddr_q;
    waddr_d   = waddr_q;
    mwdata_d  = mwdata_q;
    step      = 1'b0;

    if (enable) begin
      unique case (state_q)
        LSU_IDLE: begin
          if ((decoded_mem_read_enable || decoded_mem_write_enable) &&
              (warp_state == WARP_REQUEST)) begin
            mask_d    = thread_mask;
            is_load_d = decoded_mem_read_enable;  // read wins over write
            lane_d    = first_idx;
            coal_d    = 1'b0;
            for (int i = 0; i < int'(NUM_LANES); i++) begin
              addr_d[i]  = ADDR_W'(rs1[i*DATA_W +: DATA_W] + imm);
              wdata_d[i] = rs2[i*DATA_W +: DATA_W];
            end
            state_d = first_found ? LSU_REQUESTING : LSU_DONE;
          end
        end
        LSU_REQUESTING: begin
          if (is_load_q) begin
            rvalid_d = 1'b1;
            raddr_d  = addr_q[lane_q];
          end else begin
            wvalid_d = 1'b1;
            waddr_d  = addr_q[lane_q];
            mwdata_d = wdata_q[lane_q];
          end
          state_d = LSU_WAITING;
        end
        LSU_WAITING: begin
          // coal_q marks a coalescing step: the lane reuses the last read data
          // and the memory port is left idle.
          if (coal_q) begin
            out_d[lane_q] = hold_q;
            step          = 1'b1;
          end else if (is_load_q && mem.mem_read_ready) begin
            rvalid_d      = 1'b0;
            out_d[lane_q] = mem.mem_read_data;
            hold_d        = mem.mem_read_data;
            step          = 1'b1;
          end else if (!is_load_q && mem.mem_write_ready) begin
            wvalid_d = 1'b0;
            step     = 1'b1;
          end
          if (step) begin
            coal_d = 1'b0;
            if (!next_found) begin
              state_d = LSU_DONE;
            end else begin
              lane_d = next_idx;
              if ((COALESCE != 0) && is_load_q && (addr_q[next_idx] == addr_q[lane_q])) begin
                coal_d = 1'b1;
              end else begin
                state_d = LSU_REQUESTING;
              end
            end
          end
        end
        LSU_DONE: begin
          if (warp_state == WARP_UPDATE) state_d = LSU_IDLE;
        end
        default: state_d = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LSU_IDLE;
      is_load_q <= 1'b0;
      coal_q    <= 1'b0;
      mask_q    <= '0;
      lane_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      out_q     <= '0;
      hold_q    <= '0;
      rvalid_q  <= 1'b0;
      wvalid_q  <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      mwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      coal_q    <= coal_d;
      mask_q    <= mask_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      out_q     <= out_d;
      hold_q    <= hold_d;
      rvalid_q  <= rvalid_d;
      wvalid_q  <= wvalid_d;
      raddr_q   <= raddr_d;
      waddr_q   <= waddr_d;
      mwdata_q  <= mwdata_d;
    end
  end

  assign mem.mem_read_valid    = rvalid_q;
  assign mem.mem_read_address  = raddr_q;
  assign mem.mem_write_valid   = wvalid_q;
  assign mem.mem_write_address = waddr_q;
  assign mem.mem_write_data    = mwdata_q;
  assign lsu_state             = state_q;
  assign lsu_out               = out_q;

endmodule

// File: tb/tb_lsu_warp.sv
// Self-checking bench for lsu_warp: table of instructions with expected lane
// results/latency, a memory responder, and a request scoreboard.
module tb_lsu_warp;
  import lsu_warp_pkg::*;

  localparam int unsigned NL = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, enable, rd_en, wr_en;
  warp_state_t   warp_state;
  logic [NL-1:0] mask;
  logic [127:0]  rs1, rs2, lsu_out;
  logic [31:0]   imm;
  lsu_state_t    lsu_state;

  lsu_warp_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  lsu_warp #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .COALESCE(1)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .enable                   (enable),
    .warp_state               (warp_state),
    .decoded_mem_read_enable  (rd_en),
    .decoded_mem_write_enable (wr_en),
    .thread_mask              (mask),
    .rs1                      (rs1),
    .rs2                      (rs2),
    .imm                      (imm),
    .mem                      (mem_if.master),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  typedef struct {
    logic         rd;
    logic         wr;
    logic [3:0]   mask;
    logic [127:0] rs1;
    logic [127:0] rs2;
    logic [31:0]  imm;
    int           delay;
    logic [127:0] exp_out;
    int           exp_reqs;
    int           exp_lat;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } req_t;

  logic [31:0] mem [256];
  req_t        sb[$];
  vec_t        vecs[10];
  int          checks = 0;
  int          errors = 0;
  int          delay  = 0;
  int          n_req  = 0;

  function automatic logic [127:0] l4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic r, w, input logic [3:0] m,
                              input logic [127:0] a, d, input logic [31:0] im,
                              input int dl, input logic [127:0] eo, input int er, el);
    vec_t v;
    v.rd = r; v.wr = w; v.mask = m; v.rs1 = a; v.rs2 = d; v.imm = im;
    v.delay = dl; v.exp_out = eo; v.exp_reqs = er; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected request stream: ascending active lanes, loads skip a lane whose
  // address matches the previous active lane, stores never skip.
  task automatic push_model(input vec_t v);
    logic       have_prev = 1'b0;
    logic [7:0] prev = '0;
    for (int i = 0; i < 4; i++) begin
      if (v.mask[i]) begin
        logic [31:0] base;
        logic [31:0] sum;
        logic [7:0]  a;
        base = v.rs1[i*32 +: 32];
        sum  = base + v.imm;
        a    = sum[7:0];
        if (v.rd) begin
          if (!(have_prev && (a == prev))) sb.push_back('{wr: 1'b0, addr: a, data: 32'h0});
          prev      = a;
          have_prev = 1'b1;
        end else if (v.wr) begin
          sb.push_back('{wr: 1'b1, addr: a, data: v.rs2[i*32 +: 32]});
        end
      end
    end
  endtask

  // Memory responder: ready after `delay` cycles of valid, held while valid stays up.
  initial begin
    int cnt = 0;
    mem_if.mem_read_ready  = 1'b0;
    mem_if.mem_read_data   = '0;
    mem_if.mem_write_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_if.mem_read_valid || mem_if.mem_write_valid) begin
        if (cnt >= delay) begin
          mem_if.mem_read_ready  = mem_if.mem_read_valid;
          mem_if.mem_read_data   = mem[mem_if.mem_read_address];
          mem_if.mem_write_ready = mem_if.mem_write_valid;
        end else begin
          mem_if.mem_read_ready  = 1'b0;
          mem_if.mem_write_ready = 1'b0;
        end
        cnt++;
      end else begin
        mem_if.mem_read_ready  = 1'b0;
        mem_if.mem_write_ready = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: a handshake visible here is taken by the DUT at the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (reset_n && enable) begin
        for (int ch = 0; ch < 2; ch++) begin
          logic       hs;
          logic [7:0] a;
          hs = (ch == 0) ? (mem_if.mem_read_valid && mem_if.mem_read_ready)
                         : (mem_if.mem_write_valid && mem_if.mem_write_ready);
          a  = (ch == 0) ? mem_if.mem_read_address : mem_if.mem_write_address;
          if (hs) begin
            n_req++;
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected request: got wr=%0d addr=%0d expected none", ch, a);
            end else begin
              req_t r;
              r = sb.pop_front();
              check("req kind", 128'(ch), 128'(r.wr));
              check("req addr", 128'(a), 128'(r.addr));
              if (ch == 1) begin
                check("req wdata", 128'(mem_if.mem_write_data), 128'(r.data));
                mem[a] = mem_if.mem_write_data;
              end
            end
          end
        end
      end
    end
  end

  task automatic finish_update(input string name);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0; warp_state = WARP_UPDATE;
    @(posedge clk); #1;
    check({name, " idle"}, 128'(lsu_state), 128'(LSU_IDLE));
    @(negedge clk);
    warp_state = WARP_IDLE;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    delay = v.delay; mask = v.mask; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    rd_en = v.rd; wr_en = v.wr; warp_state = WARP_REQUEST; n_req = 0;
    push_model(v);
    @(posedge clk); #1;
    lat = 1;
    while (lsu_state != LSU_DONE && lat < 200) begin
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0; warp_state = WARP_WAIT;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d latency", idx), 128'(lat), 128'(v.exp_lat));
    check($sformatf("v%0d lsu_out", idx), lsu_out, v.exp_out);
    check($sformatf("v%0d requests", idx), 128'(n_req), 128'(v.exp_reqs));
    check($sformatf("v%0d sb empty", idx), 128'(sb.size()), 128'(0));
    finish_update($sformatf("v%0d", idx));
  endtask

  initial begin
    int viol;
    for (int i = 0; i < 256; i++) mem[i] = 32'(200 + i);
    for (int i = 0; i < 4; i++) mem[16+i] = 32'(100 + i);
    mem[8] = 32'd55;

    vecs[0] = mk(1, 0, 4'b1111, l4(0, 1, 2, 3), '0, 16, 0, l4(100, 101, 102, 103), 4, 9);
    vecs[1] = mk(0, 1, 4'b0101, l4(4, 5, 6, 7), l4(7, 8, 9, 10), 0, 0,
                 l4(100, 101, 102, 103), 2, 5);
    vecs[2] = mk(1, 0, 4'b1111, l4(8, 8, 8, 8), '0, 0, 0, l4(55, 55, 55, 55), 1, 6);
    vecs[3] = mk(1, 0, 4'b0000, l4(1, 2, 3, 4), '0, 0, 0, l4(55, 55, 55, 55), 0, 1);
    vecs[4] = mk(1, 0, 4'b1111, l4(4, 5, 6, 7), '0, 0, 2, l4(7, 205, 9, 207), 4, 17);
    vecs[5] = mk(1, 0, 4'b0011, l4(250, 32'h1ff, 0, 0), '0, 6, 0, l4(200, 205, 9, 207), 2, 5);
    vecs[6] = mk(1, 1, 4'b0001, l4(16, 0, 0, 0), l4(77, 0, 0, 0), 0, 0,
                 l4(100, 205, 9, 207), 1, 3);
    vecs[7] = mk(1, 0, 4'b1011, l4(8, 8, 3, 8), '0, 0, 0, l4(55, 55, 9, 55), 1, 5);
    vecs[8] = mk(0, 1, 4'b1111, l4(9, 9, 9, 9), l4(1, 2, 3, 4), 0, 1,
                 l4(55, 55, 9, 55), 4, 13);
    vecs[9] = mk(1, 0, 4'b0001, l4(9, 0, 0, 0), '0, 0, 0, l4(4, 55, 9, 55), 1, 3);

    reset_n = 1'b0; enable = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    warp_state = WARP_IDLE; mask = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset state", 128'(lsu_state), 128'(LSU_IDLE));
    check("reset lsu_out", lsu_out, '0);
    check("reset valids", 128'({mem_if.mem_read_valid, mem_if.mem_write_valid}), 128'(0));
    check("reset addrs", 128'({mem_if.mem_read_address, mem_if.mem_write_address,
                               mem_if.mem_write_data}), 128'(0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Slow ready with enable dropped across the point where ready arrives.
    @(negedge clk);
    delay = 5; mask = 4'b0001; rs1 = l4(17, 0, 0, 0); imm = 0;
    rd_en = 1'b1; wr_en = 1'b0; warp_state = WARP_REQUEST; n_req = 0;
    push_model(mk(1, 0, 4'b0001, l4(17, 0, 0, 0), '0, 0, 5, '0, 1, 0));
    @(posedge clk);
    viol = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      rd_en = 1'b0; warp_state = WARP_WAIT;
      enable = !(c >= 4 && c <= 7);
      #1;
      if (lsu_state == LSU_WAITING && !mem_if.mem_read_valid) viol++;
      if (lsu_state == LSU_DONE) break;
    end
    enable = 1'b1;
    check("stall done", 128'(lsu_state), 128'(LSU_DONE));
    check("stall valid held", 128'(viol), 128'(0));
    check("stall lsu_out", lsu_out, l4(101, 55, 9, 55));
    check("stall requests", 128'(n_req), 128'(1));
    check("stall sb empty", 128'(sb.size()), 128'(0));
    finish_update("stall");

    // Reset asserted while a load waits for memory.
    @(negedge clk);
    delay = 3; mask = 4'b1111; rs1 = l4(0, 1, 2, 3); imm = 16;
    rd_en = 1'b1; warp_state = WARP_REQUEST;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rd_en = 1'b0; warp_state = WARP_WAIT;
      #1;
      if (lsu_state == LSU_WAITING) break;
    end
    check("pre-reset waiting", 128'(lsu_state), 128'(LSU_WAITING));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid reset state", 128'(lsu_state), 128'(LSU_IDLE));
    check("mid reset lsu_out", lsu_out, '0);
    check("mid reset valids", 128'({mem_if.mem_read_valid, mem_if.mem_write_valid}), 128'(0));
    check("mid reset raddr", 128'(mem_if.mem_read_address), 128'(0));
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
